// File: rtl/imem_prefetch_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkg_fetch : shared types for the instruction prefetch buffer
// Rev 1.0
// ---------------------------------------------------------------------------
package pkg_fetch;

   localparam int unsigned XLen       = 32;
   localparam int unsigned InstrBytes = 4;

   typedef struct packed {
      logic [XLen-1:0] pc;
      logic [XLen-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_prefetch_buffer_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_fifo : synchronous FIFO with flush; protocol-agnostic entry storage
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_fifo
   import pkg_fetch::*;
#(
   parameter int unsigned Depth   = 4,
   parameter type         entry_t = fetch_entry_t
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  entry_t                     push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output entry_t                     head_o,
   output logic [$clog2(Depth):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   entry_t            mem_q [Depth];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic              do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Flush dominates; a push into a full FIFO is only accepted alongside a pop.
   assign do_pop  = pop_i  && !flush_i && !empty_o;
   assign do_push = push_i && !flush_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_prefetch_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_prefetch_buffer : sequential instruction prefetch with redirect/flush
// Rev 1.0
// ---------------------------------------------------------------------------
module imem_prefetch_buffer
   import pkg_fetch::*;
#(
   parameter int unsigned       DWidth  = 32,
   parameter int unsigned       Depth   = 4,
   parameter logic [DWidth-1:0] ResetPC = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   output logic              imem_req_o,
   output logic [DWidth-1:0] imem_addr_o,
   input  logic              imem_ready_i,
   input  logic [DWidth-1:0] imem_rdata_i,
   output logic              fetch_valid_o,
   output logic [DWidth-1:0] fetch_instr_o,
   output logic [DWidth-1:0] fetch_pc_o,
   input  logic              fetch_ready_i,
   input  logic              redirect_i,
   input  logic [DWidth-1:0] redirect_pc_i
);

   localparam int unsigned CntW = $clog2(Depth) + 1;

   fetch_state_e      state_q, state_d;
   logic [DWidth-1:0] addr_q, addr_d;
   logic [DWidth-1:0] pc_q, pc_d;
   logic [DWidth-1:0] redirect_tgt, pc_next;
   logic [CntW-1:0]   fifo_count, count_after_push;
   logic              fifo_full, fifo_empty;
   logic              push, pop;
   fetch_entry_t      push_entry, head;

   assign redirect_tgt     = {redirect_pc_i[DWidth-1:2], 2'b00};
   assign pc_next          = pc_q + DWidth'(InstrBytes);
   assign pop              = fetch_valid_o && fetch_ready_i && !redirect_i;
   assign count_after_push = fifo_count + CntW'(1) - CntW'(pop);
   assign push_entry       = '{pc: addr_q, instr: imem_rdata_i};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      pc_d    = pc_q;
      push    = 1'b0;
      if (redirect_i) begin
         pc_d = redirect_tgt;
      end
      unique case (state_q)
         IDLE: begin
            // A pop this cycle frees a slot, so the request may issue right away.
            if (!redirect_i && (!fifo_full || pop)) begin
               state_d = REQ;
               addr_d  = pc_q;
            end
         end
         REQ: begin
            if (imem_ready_i) begin
               if (redirect_i) begin
                  addr_d = redirect_tgt;
               end else begin
                  push = 1'b1;
                  pc_d = pc_next;
                  if (count_after_push < CntW'(Depth)) begin
                     addr_d = pc_next;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (redirect_i) begin
               state_d = DROP;
            end
         end
         DROP: begin
            // Stale response is discarded; resume at the latest redirect target.
            if (imem_ready_i) begin
               state_d = REQ;
               addr_d  = redirect_i ? redirect_tgt : pc_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= ResetPC;
         pc_q    <= ResetPC;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pc_q    <= pc_d;
      end
   end

   fetch_fifo #(
      .Depth   (Depth),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect_i),
      .head_o      (head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign imem_req_o    = (state_q != IDLE);
   assign imem_addr_o   = addr_q;
   assign fetch_valid_o = !fifo_empty;
   assign fetch_instr_o = head.instr;
   assign fetch_pc_o    = head.pc;

endmodule
`default_nettype wire

// File: tb/tb_imem_prefetch_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_prefetch_buffer : scoreboard bench with random memory latency,
// random backpressure, redirects and resets. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_prefetch_buffer;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        fvalid;
   logic [31:0] finstr, fpc;
   logic        fready = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] rpc = '0;

   always #5 clk = ~clk;

   imem_prefetch_buffer #(
      .DWidth  (32),
      .Depth   (DEPTH),
      .ResetPC (RESET_PC)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ready_i  (imem_ready),
      .imem_rdata_i  (imem_rdata),
      .fetch_valid_o (fvalid),
      .fetch_instr_o (finstr),
      .fetch_pc_o    (fpc),
      .fetch_ready_i (fready),
      .redirect_i    (redir),
      .redirect_pc_i (rpc)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] seed_next = '0;
   logic [31:0] hs_log[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          hs_cnt = 0;
   int          pop_cnt = 0;
   int          fixed_wait = 0;
   int          max_wait = 0;
   int          wait_left = -1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected stream: sequential words starting at the latest fetch origin.
   function automatic void sb_push_next();
      exp_t e;
      e.pc      = seed_next;
      e.instr   = mem_word(seed_next);
      seed_next = seed_next + 32'd4;
      exp_q.push_back(e);
   endfunction

   function automatic void sb_restart(input logic [31:0] pc);
      exp_q.delete();
      seed_next = pc;
      for (int i = 0; i < 16; i++) sb_push_next();
   endfunction

   // Memory model: responds after a per-request latency.
   always @(posedge clk) begin
      #1;
      if (!imem_req) begin
         imem_ready = 1'b0;
         wait_left  = -1;
      end else begin
         if (wait_left < 0)
            wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
         if (wait_left == 0) begin
            imem_ready = 1'b1;
            imem_rdata = mem_word(imem_addr);
            wait_left  = -1;
         end else begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            wait_left--;
         end
      end
   end

   // Monitor: protocol rules, redirect targets and scoreboard pops.
   logic        p_rst = 1'b0, p_req = 1'b0, p_ready = 1'b0, p_redir = 1'b0;
   logic [31:0] p_addr = '0;
   logic        pend_v = 1'b0;
   logic [31:0] pend_pc = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("count_le_depth", 32'(dut.fifo_count <= DEPTH), 32'd1);
         if (p_rst && p_req && !p_ready) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, p_addr);
         end
         if (p_rst && p_redir)
            chk("valid_after_redirect", 32'(fvalid), 32'd0);
         if (imem_req && (!p_req || p_ready || !p_rst) && pend_v) begin
            chk("first_req_addr", imem_addr, pend_pc);
            pend_v = 1'b0;
         end
         if (imem_req && imem_ready) begin
            hs_cnt++;
            hs_log.push_back(imem_addr);
         end
         if (fvalid && fready && !redir) begin
            if (exp_q.size() == 0) sb_push_next();
            e = exp_q.pop_front();
            chk("fetch_pc", fpc, e.pc);
            chk("fetch_instr", finstr, e.instr);
            pop_cnt++;
            while (exp_q.size() < 8) sb_push_next();
         end
         if (redir) begin
            pend_v  = 1'b1;
            pend_pc = {rpc[31:2], 2'b00};
         end
      end else begin
         pend_v  = 1'b1;
         pend_pc = RESET_PC;
      end
      p_rst   = rst_n;
      p_req   = imem_req;
      p_ready = imem_ready;
      p_addr  = imem_addr;
      p_redir = redir;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redir = 1'b0;
      sb_restart(RESET_PC);
      tick();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_valid", 32'(fvalid), 32'd0);
      chk("rst_instr", finstr, 32'd0);
      chk("rst_pc", fpc, 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic do_redirect(input logic [31:0] t);
      redir = 1'b1;
      rpc   = t;
      sb_restart({t[31:2], 2'b00});
      tick();
      redir = 1'b0;
   endtask

   int base, hbase, k, r;

   initial begin
      // Sequential fetch, zero wait, consumer always ready.
      fixed_wait = 0;
      fready     = 1'b1;
      tick();
      do_reset();
      hs_log.delete();
      base = pop_cnt;
      repeat (12) tick();
      chk("seq_rate", 32'(pop_cnt - base), 32'd10);
      for (int i = 0; i < 6; i++)
         chk("seq_addr", (i < hs_log.size()) ? hs_log[i] : 32'hDEAD_BEEF, 32'(4 * i));

      // Backpressure fills the FIFO, then a single pop reopens fetching.
      fready = 1'b0;
      do_reset();
      hbase = hs_cnt;
      repeat (10) tick();
      chk("full_req", 32'(imem_req), 32'd0);
      chk("full_valid", 32'(fvalid), 32'd1);
      chk("full_head_pc", fpc, 32'h0);
      chk("full_head_instr", finstr, mem_word(32'h0));
      chk("full_hs", 32'(hs_cnt - hbase), 32'd4);
      fready = 1'b1;
      tick();
      fready = 1'b0;
      chk("reopen_req", 32'(imem_req), 32'd1);
      chk("reopen_addr", imem_addr, 32'h10);

      // Redirect while idle and full.
      repeat (6) tick();
      chk("idle_full_req", 32'(imem_req), 32'd0);
      do_redirect(32'h100);
      chk("idle_redir_valid", 32'(fvalid), 32'd0);
      fready = 1'b1;
      repeat (20) tick();

      // Redirect during an outstanding request held for three cycles.
      fixed_wait = 3;
      do_reset();
      k = 0;
      while (!(imem_req && imem_addr == 32'h8) && k < 60) begin
         tick();
         k++;
      end
      chk("reach_req8", 32'(k < 60), 32'd1);
      do_redirect(32'h200);
      chk("drop_addr_c2", imem_addr, 32'h8);
      tick();
      chk("drop_addr_c3", imem_addr, 32'h8);
      tick();
      chk("drop_addr_c4", imem_addr, 32'h8);
      tick();
      chk("after_drop_addr", imem_addr, 32'h200);
      chk("after_drop_req", 32'(imem_req), 32'd1);
      repeat (20) tick();

      // Misaligned redirect coinciding with a pop.
      fixed_wait = -1;
      max_wait   = 1;
      k = 0;
      while (!fvalid && k < 40) begin
         tick();
         k++;
      end
      chk("reach_valid", 32'(fvalid), 32'd1);
      do_redirect(32'h102);
      chk("misalign_valid", 32'(fvalid), 32'd0);
      repeat (10) tick();

      // Reset in the middle of a request.
      fixed_wait = 5;
      k = 0;
      while (!imem_req && k < 40) begin
         tick();
         k++;
      end
      tick();
      chk("mid_req_before_rst", 32'(imem_req), 32'd1);
      do_reset();
      fixed_wait = -1;
      max_wait   = 2;
      repeat (20) tick();

      // Random traffic.
      max_wait = 3;
      for (int i = 0; i < 3000; i++) begin
         fready = ($urandom_range(99, 0) < 70);
         r = int'($urandom_range(999, 0));
         if (r < 4)
            do_reset();
         else if (r < 10)
            do_redirect(32'hFFFF_FFF0 | ($urandom & 32'hF));
         else if (r < 60)
            do_redirect($urandom & 32'h0000_FFFF);
         else
            tick();
      end
      chk("pops_seen", 32'(pop_cnt > 500), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
